mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 18 +
 rtl/mem_arbiter_rr_pick.sv | 47 ++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-client memory arbiter.
package mem_arb_pkg;
  localparam int NREQ      = 3;
  localparam int REQ_FETCH = 0;
  localparam int REQ_OPND  = 1;
  localparam int REQ_WR    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Client-side bus of the memory arbiter: per-requester req/we/addr/wdata in,
// gnt/rvalid strobes, shared rdata and busy out.
interface mem_arbiter_if #(
  parameter int n    = 8,
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   we;
  logic [NREQ*n-1:0] addr;
  logic [NREQ*n-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rvalid;
  logic [n-1:0]      rdata;
  logic              busy;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, busy);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, busy);
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner selection. Round-robin from ptr by default;
// ARB_FIXED_PRIO_EN selects fixed priority (highest index wins) instead.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IDXW-1:0] win_idx,
  output logic            any
);
  assign any = |req;

`ifdef ARB_FIXED_PRIO_EN
  // Ascending scan: the last set bit (highest index) overrides earlier ones.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_idx   = IDXW'(i);
      end
    end
  end
`else
  int  idx;
  logic found;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = IDXW'(idx);
      end
    end
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch/operand/write clients (req/gnt, one
// access in flight). Build option: ARB_FIXED_PRIO_EN (fixed priority 2>1>0).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int n    = 8,
  parameter int NREQ = mem_arb_pkg::NREQ
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  output logic         mem_we,
  output logic         mem_re,
  input  logic [n-1:0] mem_rdata
);
  localparam int IDXW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] w_q, w_d;
  logic            we_q, we_d;
  logic [n-1:0]    addr_q, addr_d;
  logic [n-1:0]    wdata_q, wdata_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic            busy_q, busy_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_re_q, mem_re_d;

  logic [NREQ-1:0] win_oh;
  logic [IDXW-1:0] win_idx;
  logic            any_req;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any_req)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    w_d      = w_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt_d    = '0;
    rvalid_d = '0;
    mem_we_d = 1'b0;
    mem_re_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          w_d      = win_idx;
          we_d     = bus.we[win_idx];
          addr_d   = bus.addr[int'(win_idx)*n +: n];
          wdata_d  = bus.wdata[int'(win_idx)*n +: n];
          // Outputs are registered, so the ACCESS-cycle strobes are set here.
          gnt_d    = win_oh;
          mem_we_d = bus.we[win_idx];
          mem_re_d = !bus.we[win_idx];
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        ptr_d = (w_q == IDXW'(NREQ-1)) ? '0 : w_q + 1'b1;
        if (we_q) begin
          state_d = IDLE;
        end else begin
          rvalid_d[w_q] = 1'b1;
          state_d       = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      w_q      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      busy_q   <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      w_q      <= w_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      mem_we_q <= mem_we_d;
      mem_re_q <= mem_re_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = busy_q;
  assign bus.rdata  = (state_q == RESP) ? mem_rdata : '0;

  // A write caught by reset in ACCESS must not reach the array on that edge.
  assign mem_we    = mem_we_q & ~reset;
  assign mem_re    = mem_re_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 1-cycle-latency memory.
module tb_mem_arbiter;
  localparam int N  = 8;
  localparam int NR = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_we, mem_re;

  logic [N-1:0] tbmem [256];
  logic         pre_en;
  logic [N-1:0] pre_addr, pre_data;

  int checks   = 0;
  int failures = 0;

  mem_arbiter_if #(.n(N), .NREQ(NR)) bus ();

  mem_arbiter #(.n(N), .NREQ(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) tbmem[pre_addr] <= pre_data;
    else if (mem_we) tbmem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= tbmem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [N-1:0] a, input logic [N-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  logic [NR-1:0] exp_seq [6];
  logic [NR-1:0] gnt_acc;
  int            ng;

  initial begin
`ifdef ARB_FIXED_PRIO_EN
    exp_seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
`else
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
    reset = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    mem_rdata = '0;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    tick(); tick();

    // Reset values
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    preload(8'h10, 8'h5A);
    reset = 1'b0;
    tick();

    // Single fetch read of 0x10
    bus.req = 3'b001; bus.we = 3'b000; bus.addr = {8'h00, 8'h00, 8'h10};
    tick();
    chk("rd_gnt", bus.gnt, 3'b001);
    chk("rd_mem_re", mem_re, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 8'h10);
    chk("rd_busy", bus.busy, 1);
    bus.req = '0;
    tick();
    chk("rd_rvalid", bus.rvalid, 3'b001);
    chk("rd_rdata", bus.rdata, 8'h5A);
    chk("rd_gnt_off", bus.gnt, 0);
    tick();
    chk("rd_busy_low", bus.busy, 0);
    chk("rd_rvalid_off", bus.rvalid, 0);
    chk("rd_rdata_idle", bus.rdata, 0);

    // Write 0xC4 to 0x03 from requester 2, then read it back via fetch
    bus.req = 3'b100; bus.we = 3'b100;
    bus.addr = {8'h03, 8'h00, 8'h00}; bus.wdata = {8'hC4, 8'h00, 8'h00};
    tick();
    chk("wr_gnt", bus.gnt, 3'b100);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_re", mem_re, 0);
    chk("wr_mem_addr", mem_addr, 8'h03);
    chk("wr_mem_wdata", mem_wdata, 8'hC4);
    bus.req = '0;
    tick();
    chk("wr_mem_we_pulse", mem_we, 0);
    chk("wr_busy_low", bus.busy, 0);
    chk("wr_mem_content", tbmem[8'h03], 8'hC4);
    bus.req = 3'b001; bus.we = 3'b100; bus.addr = {8'h03, 8'h00, 8'h03};
    tick();
    chk("rb_gnt", bus.gnt, 3'b001);
    bus.req = '0;
    tick();
    chk("rb_rvalid", bus.rvalid, 3'b001);
    chk("rb_rdata", bus.rdata, 8'hC4);

    // All three requesting continuously from reset
    reset = 1'b1;
    bus.req = 3'b111; bus.we = 3'b100;
    bus.addr = {8'h22, 8'h21, 8'h20}; bus.wdata = {8'h99, 8'h00, 8'h00};
    tick();
    reset = 1'b0;
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      tick();
      if (bus.gnt != 0) begin
        chk($sformatf("arb_grant%0d", ng), bus.gnt, exp_seq[ng]);
        ng++;
      end
    end
    chk("arb_grant_count", ng, 6);

    // Requester 1 drops req while requester 0 is in RESP
    reset = 1'b1; bus.req = '0;
    tick();
    reset = 1'b0;
    tick();
    bus.req = 3'b011; bus.we = 3'b000; bus.addr = {8'h00, 8'h31, 8'h30};
    tick();
    chk("drop_gnt0", bus.gnt, 3'b001);
    bus.req = 3'b010;
    tick();
    chk("drop_rvalid0", bus.rvalid, 3'b001);
    bus.req = 3'b000;
    gnt_acc = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      gnt_acc |= bus.gnt;
    end
    chk("drop_no_gnt", gnt_acc, 0);
    chk("drop_idle", bus.busy, 0);

    // Reset during ACCESS of a write to 0x07
    preload(8'h07, 8'h11);
    bus.req = 3'b100; bus.we = 3'b100;
    bus.addr = {8'h07, 8'h00, 8'h00}; bus.wdata = {8'hEE, 8'h00, 8'h00};
    tick();
    chk("rstw_gnt", bus.gnt, 3'b100);
    reset = 1'b1; bus.req = '0;
    tick();
    chk("rstw_mem_kept", tbmem[8'h07], 8'h11);
    chk("rstw_gnt_off", bus.gnt, 0);
    chk("rstw_rvalid_off", bus.rvalid, 0);
    chk("rstw_busy", bus.busy, 0);
    chk("rstw_mem_we", mem_we, 0);
    chk("rstw_mem_re", mem_re, 0);
    chk("rstw_mem_addr", mem_addr, 0);
    chk("rstw_mem_wdata", mem_wdata, 0);
    reset = 1'b0;
    tick();
    chk("rstw_mem_after", tbmem[8'h07], 8'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
